// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a commanded number of words from a lookahead FIFO
//   and presents them downstream as a registered valid/ready stream.
// Latency: the FIFO head word appears on data_o one cycle after its pop;
//   throughput is 1 word/cycle.
// Backpressure: no pop while the output register is full and stalled; an
//   empty FIFO stalls the burst with no timeout.
//
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   cmd_v_i/cmd_len_i/cmd_ready_o  burst command (length 0..max_burst_p, larger is clamped)
//   fifo_rd_o/fifo_data_i/fifo_empty_i  FIFO read side (lookahead head word)
//   data_v_o/data_o/data_last_o/data_ready_i  output stream, last marks final beat
//   busy_o                      high while a burst is in progress
//   done_o                      one-cycle pulse when a burst completes
// Optional: define FIFO_BURST_READER_ABORT_EN to add abort_i / aborted_o, which
//   cancel an in-flight burst and leave unconsumed words in the FIFO.
module fifo_burst_reader #(
  parameter int data_width_p = 4,
  parameter int max_burst_p  = 16,
  localparam int LW          = $clog2(max_burst_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    cmd_v_i,
  input  logic [LW-1:0]           cmd_len_i,
  output logic                    cmd_ready_o,
  output logic                    fifo_rd_o,
  input  logic [data_width_p-1:0] fifo_data_i,
  input  logic                    fifo_empty_i,
  output logic                    data_v_o,
  output logic [data_width_p-1:0] data_o,
  output logic                    data_last_o,
  input  logic                    data_ready_i,
`ifdef FIFO_BURST_READER_ABORT_EN
  input  logic                    abort_i,
  output logic                    aborted_o,
`endif
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;

  state_e                  state_r, state_n;
  logic [LW-1:0]           remaining_r, remaining_n;
  logic [data_width_p-1:0] data_r, data_n;
  logic                    data_v_r, data_v_n;
  logic                    data_last_r, data_last_n;
  logic                    done_r, done_n;
  logic [LW-1:0]           len_clamped;
  logic                    beat_acc;
  logic                    pop;

`ifdef FIFO_BURST_READER_ABORT_EN
  logic aborted_r, aborted_n;
  logic abort_act;

  // Abort only means something while a burst is in flight.
  assign abort_act = abort_i & (state_r != IDLE);
  assign aborted_o = aborted_r;
`endif

  // Oversized lengths are clamped rather than rejected.
  assign len_clamped = (cmd_len_i > LW'(max_burst_p)) ? LW'(max_burst_p) : cmd_len_i;

  assign beat_acc = data_v_r & data_ready_i;

  // Pop only into a free (or simultaneously emptying) output register; the
  // reset term keeps the FIFO untouched while reset is held mid-burst.
  assign pop = (state_r == BURST) & (remaining_r != '0) & ~fifo_empty_i &
               (~data_v_r | data_ready_i) & ~reset_i
`ifdef FIFO_BURST_READER_ABORT_EN
               & ~abort_act
`endif
               ;

  always_comb begin
    state_n     = state_r;
    remaining_n = remaining_r;
    data_n      = data_r;
    data_v_n    = data_v_r;
    data_last_n = data_last_r;
    done_n      = 1'b0;
`ifdef FIFO_BURST_READER_ABORT_EN
    aborted_n   = 1'b0;
`endif

    case (state_r)
      IDLE: begin
        if (cmd_v_i) begin
          remaining_n = len_clamped;
          if (len_clamped != '0) state_n = BURST;
          else                   done_n  = 1'b1;   // zero-length burst completes at once
        end
      end
      BURST: begin
        if (pop && remaining_r == LW'(1)) state_n = DRAIN;
      end
      DRAIN: begin
        if (beat_acc && data_last_r) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Pop refills the register even when the current beat leaves this cycle,
    // so a steady stream has no bubbles.
    if (pop) begin
      data_n      = fifo_data_i;
      data_v_n    = 1'b1;
      data_last_n = (remaining_r == LW'(1));
      remaining_n = remaining_r - LW'(1);
    end else if (beat_acc) begin
      data_v_n = 1'b0;
    end

`ifdef FIFO_BURST_READER_ABORT_EN
    // Abort wins over everything else; a beat accepted this cycle still counts.
    if (abort_act) begin
      state_n     = IDLE;
      data_v_n    = 1'b0;
      remaining_n = '0;
      done_n      = 1'b1;
      aborted_n   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      remaining_r <= '0;
      data_r      <= '0;
      data_v_r    <= 1'b0;
      data_last_r <= 1'b0;
      done_r      <= 1'b0;
`ifdef FIFO_BURST_READER_ABORT_EN
      aborted_r   <= 1'b0;
`endif
    end else begin
      state_r     <= state_n;
      remaining_r <= remaining_n;
      data_r      <= data_n;
      data_v_r    <= data_v_n;
      data_last_r <= data_last_n;
      done_r      <= done_n;
`ifdef FIFO_BURST_READER_ABORT_EN
      aborted_r   <= aborted_n;
`endif
    end
  end

  // cmd_ready_o is forced high while reset is held, matching the idle state
  // the block is about to enter.
  assign cmd_ready_o = (state_r == IDLE) | reset_i;
  assign fifo_rd_o   = pop;
  assign data_v_o    = data_v_r;
  assign data_o      = data_r;
  assign data_last_o = data_last_r;
  assign busy_o      = (state_r != IDLE);
  assign done_o      = done_r;

endmodule
